fifo_fwft_sync: RTL and testbench

// - Single-clock first-word-fall-through FIFO with a valid/ready egress and registered status outputs.
// - Successor to the async-FIFO-plus-prefetch-register wrapper, for paths that need no CDC:
//   - RAM-style memory plus one output prefetch register.
//   - Almost-full / almost-empty thresholds.
//   - Sticky overflow flag.
//   - Optional max-fill watermark.
// - Used as the generic buffer between streaming blocks in one clock domain.

---
 rtl/fifo_fwft_sync.sv | 92 +++++++++
 tb/tb_fifo_fwft_sync.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_sync.sv
// fifo_fwft_sync: single-clock FWFT FIFO, RAM plus one prefetch register, registered status.
// Define FIFO_FWFT_SYNC_WATERMARK_EN to build the max-fill watermark; otherwise it reads 0.
module fifo_fwft_sync #(
  parameter int DATA_WIDTH_P = 8,
  parameter int ADDR_WIDTH_P = 4,
  parameter int AF_LEVEL_P   = 14,
  parameter int AE_LEVEL_P   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ing_enable,
  input  logic [DATA_WIDTH_P-1:0] ing_data,
  output logic                    ing_full,
  output logic                    ing_almost_full,
  output logic [DATA_WIDTH_P-1:0] egr_data,
  output logic                    egr_valid,
  input  logic                    egr_ready,
  output logic                    egr_almost_empty,
  input  logic                    cr_clear_errors,
  input  logic                    cr_clear_max,
  output logic [ADDR_WIDTH_P:0]   sr_fill_level,
  output logic [ADDR_WIDTH_P:0]   sr_max_fill_level,
  output logic                    sr_overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH_P;
  localparam int PW = ADDR_WIDTH_P + 1;
  localparam logic [31:0] AF_W = AF_LEVEL_P;
  localparam logic [31:0] AE_W = AE_LEVEL_P;
  localparam logic [ADDR_WIDTH_P:0] AF_L = AF_W[ADDR_WIDTH_P:0];
  localparam logic [ADDR_WIDTH_P:0] AE_L = AE_W[ADDR_WIDTH_P:0];
  localparam logic [ADDR_WIDTH_P:0] MSB_ONLY = {1'b1, {ADDR_WIDTH_P{1'b0}}};

  logic [DATA_WIDTH_P-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH_P:0]   r_wptr, r_rptr, r_fill, w_fill_nxt;
  logic [DATA_WIDTH_P-1:0] r_data;
  logic                    r_valid, r_af, r_ae, r_ovf;
  logic                    w_full, w_empty, w_wr, w_xfer, w_load;

  assign w_full     = (r_wptr ^ r_rptr) == MSB_ONLY;
  assign w_empty    = r_wptr == r_rptr;
  assign w_wr       = ing_enable && !w_full;
  assign w_xfer     = r_valid && egr_ready;
  // the prefetch register refills whenever it is empty or being drained this cycle
  assign w_load     = !w_empty && (!r_valid || egr_ready);
  assign w_fill_nxt = r_fill + PW'(w_wr) - PW'(w_xfer);

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr[ADDR_WIDTH_P-1:0]] <= ing_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fill  <= '0;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_wr);
      r_rptr  <= r_rptr + PW'(w_load);
      r_data  <= w_load ? r_mem[r_rptr[ADDR_WIDTH_P-1:0]] : r_data;
      r_valid <= w_load ? 1'b1 : (w_xfer ? 1'b0 : r_valid);
      r_fill  <= w_fill_nxt;
      r_af    <= w_fill_nxt >= AF_L;
      r_ae    <= w_fill_nxt <= AE_L;
      r_ovf   <= (ing_enable && w_full) ? 1'b1 : (cr_clear_errors ? 1'b0 : r_ovf);
    end
  end

`ifdef FIFO_FWFT_SYNC_WATERMARK_EN
  logic [ADDR_WIDTH_P:0] r_max;
  always_ff @(posedge clk) begin
    if (rst) r_max <= '0;
    else r_max <= cr_clear_max ? r_fill : (r_fill > r_max ? r_fill : r_max);
  end
  assign sr_max_fill_level = r_max;
`else
  logic w_unused_clear_max;
  assign w_unused_clear_max = cr_clear_max;
  assign sr_max_fill_level  = '0;
`endif

  assign ing_full         = w_full;
  assign ing_almost_full  = r_af;
  assign egr_data         = r_data;
  assign egr_valid        = r_valid;
  assign egr_almost_empty = r_ae;
  assign sr_fill_level    = r_fill;
  assign sr_overflow      = r_ovf;
endmodule

// File: tb/tb_fifo_fwft_sync.sv
// tb_fifo_fwft_sync: scoreboard bench for fifo_fwft_sync at default parameters.
module tb_fifo_fwft_sync;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ing_enable = 1'b0;
  logic [7:0] ing_data = '0;
  logic       ing_full, ing_almost_full, egr_valid, egr_almost_empty, sr_overflow;
  logic [7:0] egr_data;
  logic       egr_ready = 1'b0;
  logic       cr_clear_errors = 1'b0;
  logic       cr_clear_max = 1'b0;
  logic [4:0] sr_fill_level, sr_max_fill_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  int m_mem = 0;
  int m_valid = 0;

  fifo_fwft_sync dut (
    .clk(clk), .rst(rst), .ing_enable(ing_enable), .ing_data(ing_data),
    .ing_full(ing_full), .ing_almost_full(ing_almost_full),
    .egr_data(egr_data), .egr_valid(egr_valid), .egr_ready(egr_ready),
    .egr_almost_empty(egr_almost_empty), .cr_clear_errors(cr_clear_errors),
    .cr_clear_max(cr_clear_max), .sr_fill_level(sr_fill_level),
    .sr_max_fill_level(sr_max_fill_level), .sr_overflow(sr_overflow)
  );

  always #5 clk = ~clk;

  // advances one edge; the model follows the spec's accept/prefetch rules and
  // checks each transferred word against the scoreboard head
  task automatic tick();
    bit acc, xfer, load;
    logic [7:0] exp_d;
    acc  = ing_enable && (m_mem < 16);
    xfer = (m_valid == 1) && egr_ready;
    load = (m_mem > 0) && ((m_valid == 0) || egr_ready);
    if (rst) begin
      q.delete();
      m_mem = 0;
      m_valid = 0;
    end else begin
      if (acc) q.push_back(ing_data);
      if (xfer) begin
        exp_d = q.pop_front();
        checks++;
        if (!egr_valid || egr_data !== exp_d) begin
          errors++;
          $display("FAIL pop_data: got valid=%0b data=%0h, need valid=1 data=%0h", egr_valid, egr_data, exp_d);
        end
      end
      m_mem = m_mem + int'(acc) - int'(load);
      m_valid = load ? 1 : (xfer ? 0 : m_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ing_enable = 1'b0;
    egr_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({egr_valid, ing_full, ing_almost_full, egr_almost_empty, sr_overflow} !== 5'b00010 ||
        sr_fill_level !== 5'd0 || egr_data !== 8'd0 || sr_max_fill_level !== 5'd0) begin
      errors++;
      $display("FAIL reset: got v=%0b f=%0b af=%0b ae=%0b ovf=%0b lvl=%0d d=%0h max=%0d, need 0 0 0 1 0 0 0 0",
               egr_valid, ing_full, ing_almost_full, egr_almost_empty, sr_overflow, sr_fill_level, egr_data, sr_max_fill_level);
    end
  endtask

  task automatic test_first_word();
    ing_enable = 1'b1;
    ing_data = 8'hA5;
    tick();
    ing_enable = 1'b0;
    checks++;
    if (egr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_early: got valid=%0b, need 0", egr_valid);
    end
    tick();
    checks++;
    if (egr_valid !== 1'b1 || egr_data !== 8'hA5 || sr_fill_level !== 5'd1 || egr_almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL first_word: got v=%0b d=%0h lvl=%0d ae=%0b, need 1 a5 1 1", egr_valid, egr_data, sr_fill_level, egr_almost_empty);
    end
  endtask

  task automatic test_fill();
    egr_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ing_enable = 1'b1;
      ing_data = 8'(i);
      tick();
      checks++;
      if (sr_fill_level !== 5'(i + 1) || ing_almost_full !== (i + 1 >= 14) || egr_almost_empty !== (i + 1 <= 2)) begin
        errors++;
        $display("FAIL fill_%0d: got lvl=%0d af=%0b ae=%0b, need %0d %0b %0b", i, sr_fill_level, ing_almost_full,
                 egr_almost_empty, i + 1, i + 1 >= 14, i + 1 <= 2);
      end
    end
    checks++;
    if (ing_full !== 1'b1 || sr_overflow !== 1'b0 || egr_data !== 8'd0) begin
      errors++;
      $display("FAIL full_flag: got full=%0b ovf=%0b d=%0h, need 1 0 0", ing_full, sr_overflow, egr_data);
    end
    ing_data = 8'd99;
    tick();
    checks++;
    if (sr_overflow !== 1'b1 || sr_fill_level !== 5'd17) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%0b lvl=%0d, need 1 17", sr_overflow, sr_fill_level);
    end
    cr_clear_errors = 1'b1;
    tick();
    checks++;
    if (sr_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_priority: got %0b, need 1", sr_overflow);
    end
    ing_enable = 1'b0;
    tick();
    cr_clear_errors = 1'b0;
    checks++;
    if (sr_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %0b, need 0", sr_overflow);
    end
  endtask

  task automatic test_drain();
    egr_ready = 1'b1;
    ing_enable = 1'b1;
    ing_data = 8'd77;
    tick();
    ing_enable = 1'b0;
    checks++;
    if (ing_full !== 1'b0 || sr_overflow !== 1'b1 || sr_fill_level !== 5'd16) begin
      errors++;
      $display("FAIL first_pop: got full=%0b ovf=%0b lvl=%0d, need 0 1 16", ing_full, sr_overflow, sr_fill_level);
    end
    for (int i = 1; i < 17; i++) tick();
    checks++;
    if (egr_valid !== 1'b0 || sr_fill_level !== 5'd0 || q.size() != 0) begin
      errors++;
      $display("FAIL drained: got v=%0b lvl=%0d left=%0d, need 0 0 0", egr_valid, sr_fill_level, q.size());
    end
    egr_ready = 1'b0;
  endtask

  task automatic test_stream();
    int bad = 0;
    do_reset();
    egr_ready = 1'b1;
    ing_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ing_data = 8'(i * 7 + 3);
      tick();
      if (i > 0 && sr_fill_level !== 5'd2) bad++;
    end
    ing_enable = 1'b0;
    checks++;
    if (bad != 0 || sr_overflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_level: got %0d cycles off level 2, ovf=%0b, need 0 0", bad, sr_overflow);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (egr_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: got v=%0b left=%0d, need 0 0", egr_valid, q.size());
    end
    egr_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    ing_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ing_data = 8'(i + 40);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ing_enable = 1'b0;
    checks++;
    if (egr_valid !== 1'b0 || sr_fill_level !== 5'd0 || ing_full !== 1'b0 || egr_almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b lvl=%0d full=%0b ae=%0b, need 0 0 0 1", egr_valid, sr_fill_level, ing_full, egr_almost_empty);
    end
  endtask

  task automatic test_watermark();
    logic [4:0] exp_hi, exp_lo;
`ifdef FIFO_FWFT_SYNC_WATERMARK_EN
    exp_hi = 5'd12;
    exp_lo = 5'd3;
`else
    exp_hi = 5'd0;
    exp_lo = 5'd0;
`endif
    do_reset();
    ing_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ing_data = 8'(i + 200);
      tick();
    end
    ing_enable = 1'b0;
    egr_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    egr_ready = 1'b0;
    tick();
    checks++;
    if (sr_fill_level !== 5'd3 || sr_max_fill_level !== exp_hi) begin
      errors++;
      $display("FAIL watermark_peak: got lvl=%0d max=%0d, need 3 %0d", sr_fill_level, sr_max_fill_level, exp_hi);
    end
    cr_clear_max = 1'b1;
    tick();
    cr_clear_max = 1'b0;
    tick();
    checks++;
    if (sr_max_fill_level !== exp_lo) begin
      errors++;
      $display("FAIL watermark_clear: got %0d, need %0d", sr_max_fill_level, exp_lo);
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    do_reset();
    test_fill();
    test_drain();
    test_stream();
    test_mid_reset();
    test_watermark();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
